// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - instruction-fetch / data port arbiter for a single-ported synchronous-read memory
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_stall,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [31:0]           conflict_cnt
);

    // Owner of the read response returning from the memory this cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_PEND = 2'd1,
        D_PEND  = 2'd2
    } state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        pend_store_q, pend_store_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    logic        if_elig;
    logic        d_elig;
    logic        grant_if;
    logic        grant_d;

    // A port whose response is still in flight is not eligible; this is what
    // keeps a continuously-held request to at most one grant every other cycle.
    always_comb begin
        if_elig = if_req && (state_q != IF_PEND);
        d_elig  = d_req  && (state_q != D_PEND);
    end

    // Grant selection; nothing is granted while reset is held so no access
    // (in particular no write) reaches the memory during reset.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst) begin
            if (if_elig && d_elig) begin
                if (DATA_PRIORITY != 0) begin
                    grant_d = 1'b1;
                end else if (last_grant_q == GRANT_D) begin
                    grant_if = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_if = if_elig;
                grant_d  = d_elig;
            end
        end
    end

    // Memory request mux: the granted port's address, write only for a data store.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            mem_wdata = d_wdata;
        end
    end

    // Next-state logic: the state records who owns next cycle's response.
    always_comb begin
        state_d        = IDLE;
        last_grant_d   = last_grant_q;
        pend_store_d   = 1'b0;
        conflict_cnt_d = conflict_cnt_q;
        if (grant_if) begin
            state_d      = IF_PEND;
            last_grant_d = GRANT_IF;
        end else if (grant_d) begin
            state_d      = D_PEND;
            last_grant_d = GRANT_D;
            pend_store_d = d_we;
        end
        if (if_elig && grant_d) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    // State register; reset discards any outstanding response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_D;
            pend_store_q   <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pend_store_q   <= pend_store_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Responses and stalls; valid is masked by rst so a response whose
    // owner is being reset never pulses.
    always_comb begin
        if_valid = (state_q == IF_PEND) && !rst;
        d_valid  = (state_q == D_PEND)  && !rst;
        if_rdata = if_valid ? mem_rdata : '0;
        d_rdata  = (d_valid && !pend_store_q) ? mem_rdata : '0;
        if_stall = if_req && !if_valid;
        d_stall  = d_req  && !d_valid;
    end

    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic        if_valid_a, if_stall_a, d_valid_a, d_stall_a, mem_en_a, mem_we_a;
    logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a, conflict_cnt_a;
    logic        if_valid_b, if_stall_b, d_valid_b, d_stall_b, mem_en_b, mem_we_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b, conflict_cnt_b;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid_a), .if_rdata(if_rdata_a), .if_stall(if_stall_a),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid_a), .d_rdata(d_rdata_a), .d_stall(d_stall_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .conflict_cnt(conflict_cnt_a)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid_b), .if_rdata(if_rdata_b), .if_stall(if_stall_b),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid_b), .d_rdata(d_rdata_b), .d_stall(d_stall_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .conflict_cnt(conflict_cnt_b)
    );

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic        mem_ready = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            1:       return 32'h0000_0013;
            2:       return 32'h0050_0093;
            16:      return 32'h1234_5678;
            default: return 32'h0;
        endcase
    endfunction

    // Synchronous-read memories, preloaded on the first clock edge.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
            mem_rdata_a <= 32'h0;
            mem_rdata_b <= 32'h0;
            mem_ready   <= 1'b1;
        end else begin
            if (mem_en_a) begin
                if (mem_we_a) mem_a[mem_addr_a[7:2]] <= mem_wdata_a;
                else          mem_rdata_a <= mem_a[mem_addr_a[7:2]];
            end
            if (mem_en_b) begin
                if (mem_we_b) mem_b[mem_addr_b[7:2]] <= mem_wdata_b;
                else          mem_rdata_b <= mem_b[mem_addr_b[7:2]];
            end
        end
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] sb_if [$];
    logic [31:0] sb_d  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_if(input string tag);
        logic [31:0] e;
        chk({tag, "_if_valid"}, {31'b0, if_valid_a}, 32'd1);
        e = (sb_if.size() > 0) ? sb_if.pop_front() : 32'hFFFF_FFFF;
        chk({tag, "_if_rdata"}, if_rdata_a, e);
    endtask

    task automatic pop_d(input string tag);
        logic [31:0] e;
        chk({tag, "_d_valid"}, {31'b0, d_valid_a}, 32'd1);
        e = (sb_d.size() > 0) ? sb_d.pop_front() : 32'hFFFF_FFFF;
        chk({tag, "_d_rdata"}, d_rdata_a, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_addr = 32'h40; d_we = 1'b0; d_wdata = 32'h0;

        // Reset with both requests active
        step(); #1;
        chk("rst1_mem_en", {31'b0, mem_en_a}, 32'd0);
        chk("rst1_if_valid", {31'b0, if_valid_a}, 32'd0);
        chk("rst1_d_valid", {31'b0, d_valid_a}, 32'd0);
        chk("rst1_conflict_cnt", conflict_cnt_a, 32'd0);
        step(); #1;
        chk("rst2_mem_en", {31'b0, mem_en_a}, 32'd0);
        chk("rst2_conflict_cnt", conflict_cnt_a, 32'd0);

        // Conflict under data priority, starting in the cycle rst falls
        rst = 1'b0;
        sb_d.push_back(32'h1234_5678);
        sb_if.push_back(32'h0000_0013);
        #1;
        chk("first_grant_mem_en", {31'b0, mem_en_a}, 32'd1);
        chk("conf_t_mem_addr", mem_addr_a, 32'h40);
        chk("conf_t_if_stall", {31'b0, if_stall_a}, 32'd1);
        step(); #1;
        pop_d("conf_load");
        chk("conf_t1_mem_addr", mem_addr_a, 32'h4);
        chk("conf_t1_if_stall", {31'b0, if_stall_a}, 32'd1);
        step(); d_req = 1'b0; #1;
        pop_if("conf_fetch");
        chk("conflict_cnt_1", conflict_cnt_a, 32'd1);
        step(); if_req = 1'b0; #1;
        chk("idle_mem_en", {31'b0, mem_en_a}, 32'd0);

        // Lone fetch
        step(); if_req = 1'b1; if_addr = 32'h8; sb_if.push_back(32'h0050_0093); #1;
        chk("fetch_mem_en", {31'b0, mem_en_a}, 32'd1);
        chk("fetch_mem_addr", mem_addr_a, 32'h8);
        chk("fetch_if_stall_t", {31'b0, if_stall_a}, 32'd1);
        step(); #1;
        pop_if("fetch");
        chk("fetch_if_stall_t1", {31'b0, if_stall_a}, 32'd0);
        step(); if_req = 1'b0; #1;

        // Store then load-back
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        sb_d.push_back(32'h0); #1;
        chk("store_mem_we", {31'b0, mem_we_a}, 32'd1);
        chk("store_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
        chk("store_mem_addr", mem_addr_a, 32'h10);
        step(); #1;
        pop_d("store_ack");
        step(); d_we = 1'b0; sb_d.push_back(32'hDEAD_BEEF); #1;
        chk("load_back_mem_we", {31'b0, mem_we_a}, 32'd0);
        chk("load_back_mem_en", {31'b0, mem_en_a}, 32'd1);
        step(); #1;
        pop_d("load_back");
        step(); d_req = 1'b0; #1;

        // Reset in the cycle after a fetch grant, with a store attempted under reset
        step(); if_req = 1'b1; if_addr = 32'h8; #1;
        chk("pre_rst_grant", {31'b0, mem_en_a}, 32'd1);
        step(); rst = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D; #1;
        chk("rst_mid_if_valid", {31'b0, if_valid_a}, 32'd0);
        chk("rst_mid_mem_we", {31'b0, mem_we_a}, 32'd0);
        chk("rst_mid_mem_en", {31'b0, mem_en_a}, 32'd0);
        step(); rst = 1'b0; d_req = 1'b0; d_we = 1'b0; sb_if.push_back(32'h0050_0093); #1;
        chk("post_rst_if_valid", {31'b0, if_valid_a}, 32'd0);
        chk("post_rst_mem_addr", mem_addr_a, 32'h8);
        chk("post_rst_conflict_cnt", conflict_cnt_a, 32'd0);
        step(); #1;
        pop_if("post_rst_fetch");
        step(); if_req = 1'b0; #1;
        step(); d_req = 1'b1; d_addr = 32'h20; sb_d.push_back(32'h0); #1;
        step(); #1;
        pop_d("rst_write_absent");
        step(); d_req = 1'b0; #1;

        // Round-robin instance: last_grant = data after reset
        step(); rst = 1'b1; #1;
        step(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_addr = 32'h40; #1;
        chk("rr_first_fetch_addr", mem_addr_b, 32'h8);
        chk("rr_first_mem_we", {31'b0, mem_we_b}, 32'd0);
        step(); #1;
        chk("rr_if_valid", {31'b0, if_valid_b}, 32'd1);
        chk("rr_if_rdata", if_rdata_b, 32'h0050_0093);
        chk("rr_second_data_addr", mem_addr_b, 32'h40);
        step(); if_addr = 32'h4; #1;
        chk("rr_d_valid", {31'b0, d_valid_b}, 32'd1);
        chk("rr_d_rdata", d_rdata_b, 32'h1234_5678);
        chk("rr_fetch_again_addr", mem_addr_b, 32'h4);
        step(); d_req = 1'b0; #1;
        chk("rr_if_valid2", {31'b0, if_valid_b}, 32'd1);
        chk("rr_if_rdata2", if_rdata_b, 32'h0000_0013);
        step(); if_req = 1'b0; #1;
        step(); if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_addr = 32'h40; #1;
        chk("rr_repeat_data_first", mem_addr_b, 32'h40);
        step(); #1;
        chk("rr_repeat_d_valid", {31'b0, d_valid_b}, 32'd1);
        chk("rr_repeat_fetch_second", mem_addr_b, 32'h8);
        step(); d_req = 1'b0; #1;
        chk("rr_repeat_if_valid", {31'b0, if_valid_b}, 32'd1);
        step(); if_req = 1'b0; #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
